// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for uart_rx: oversample tick, uart_rx sync reset,
// byte capture into a first-word-fall-through FIFO, overrun/timeout flags and IRQ.
module uart_rx_ctrl #(
    parameter int unsigned BAUD_DIV  = 164,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned IRQ_LEVEL = 1,
    parameter int unsigned TO_TICKS  = 192
) (
    input  logic                   CLOCK_RX,
    input  logic                   NRESET,
    input  logic                   EN,
    input  logic                   NINTI,
    input  logic [7:0]             RX_DATA,
    output logic                   S_TICK,
    output logic                   RX_RST,
    input  logic                   RD_EN,
    output logic [7:0]             DOUT,
    output logic                   EMPTY,
    output logic                   FULL,
    output logic [$clog2(DEPTH):0] COUNT,
    input  logic                   CLR_ERR,
    output logic                   OVERRUN,
    output logic                   TIMEOUT,
    output logic                   IRQ
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = $clog2(BAUD_DIV + 1);
    localparam int unsigned TW = $clog2(TO_TICKS + 1);

    typedef enum logic {TO_IDLE, TO_BUSY} to_state_e;

    logic          rx_rst_q, rx_rst_d;
    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;
    logic          ninti_q;
    logic          active;
    logic          wr, pop, push, overrun_set;
    logic          full, empty;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic          irq_q, irq_d;

    to_state_e     state_q, state_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_event;

    assign active = EN & ~rx_rst_q;

    // ---------------- uart_rx reset and baud divider ----------------
    always_comb begin
        rx_rst_d = ~EN | to_event;
        div_d    = '0;
        tick_d   = 1'b0;
        if (active) begin
            tick_d = (div_q == DW'(BAUD_DIV - 1));
            div_d  = tick_d ? '0 : div_q + DW'(1);
        end
    end

    always_ff @(posedge CLOCK_RX or negedge NRESET) begin
        if (!NRESET) begin
            rx_rst_q <= 1'b1;
            div_q    <= '0;
            tick_q   <= 1'b0;
            ninti_q  <= 1'b1;
        end else begin
            rx_rst_q <= rx_rst_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            ninti_q  <= NINTI;
        end
    end

    // ---------------- capture and FIFO ----------------
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A simultaneous pop frees the slot, so a write into a full FIFO is not an overrun.
    assign wr          = NINTI & ~ninti_q & ~rx_rst_q;
    assign pop         = RD_EN & ~empty;
    assign push        = wr & (~full | pop);
    assign overrun_set = wr & full & ~pop;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLOCK_RX or negedge NRESET) begin
        if (!NRESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= RX_DATA;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ---------------- stuck-receive timeout FSM ----------------
    always_ff @(posedge CLOCK_RX or negedge NRESET) begin
        if (!NRESET) begin
            state_q  <= TO_IDLE;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        if (!active) begin
            state_d  = TO_IDLE;
            to_cnt_d = '0;
        end else begin
            case (state_q)
                TO_IDLE: begin
                    if (ninti_q && !NINTI) begin
                        state_d  = TO_BUSY;
                        to_cnt_d = '0;
                    end
                end
                TO_BUSY: begin
                    if (NINTI) begin
                        state_d = TO_IDLE;
                    end else if (to_event) begin
                        state_d  = TO_IDLE;
                        to_cnt_d = '0;
                    end else if (tick_q) begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                end
                default: begin
                    state_d  = TO_IDLE;
                    to_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        to_event = active && (state_q == TO_BUSY) && !NINTI && tick_q
                   && (to_cnt_q == TW'(TO_TICKS - 1));
    end

    // ---------------- sticky flags and interrupt ----------------
    always_comb begin
        overrun_d = overrun_set | (overrun_q & ~CLR_ERR);
        timeout_d = to_event    | (timeout_q & ~CLR_ERR);
        irq_d     = (count_d >= CW'(IRQ_LEVEL)) | overrun_d | timeout_d;
    end

    always_ff @(posedge CLOCK_RX or negedge NRESET) begin
        if (!NRESET) begin
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            irq_q     <= irq_d;
        end
    end

    assign S_TICK  = tick_q;
    assign RX_RST  = rx_rst_q;
    assign DOUT    = mem_q[rd_ptr_q];
    assign EMPTY   = empty;
    assign FULL    = full;
    assign COUNT   = count_q;
    assign OVERRUN = overrun_q;
    assign TIMEOUT = timeout_q;
    assign IRQ     = irq_q;

endmodule
